// File: rtl/ram_dp_mem_if.sv
// ram_dp_mem_if: write/read bus for ram_dp_mem
// master drives write/read requests; slave returns read data, status and write error.
interface ram_dp_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                wr_enb;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic                rd_enb;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_err;
    logic                wr_err;
    modport master (
        output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
        input  rd_data, rd_valid, rd_err, wr_err
    );
    modport slave (
        input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
        output rd_data, rd_valid, rd_err, wr_err
    );
endinterface

// File: rtl/ram_dp_mem.sv
// ram_dp_mem: byte-enabled simple dual-port RAM, write-first, pipelined reads (RD_LAT 1 or 2)
// Ports: clk, rst (sync, active high); bus (slave): write port wr_enb/wr_addr/wr_data/wr_be,
// read port rd_enb/rd_addr, responses rd_data/rd_valid/rd_err, and wr_err for out-of-range writes.
module ram_dp_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    ram_dp_mem_if.slave bus
);
    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable and the compare never wraps.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] d1_q;
    logic              wr_in, rd_in, wr_err_q, v1_q, e1_q;

    assign wr_in = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in = {1'b0, bus.rd_addr} < DEPTH_W;
    assign bus.wr_err = wr_err_q;

    // Read from the post-write image so a same-cycle collision is write-first;
    // an out-of-range address matches no word and yields zero.
    always_comb begin
        mem_d = mem_q;
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_enb && wr_in && bus.wr_addr == ADDR_W'(i) && bus.wr_be[b])
                    mem_d[i][8*b +: 8] = bus.wr_data[8*b +: 8];
            if (bus.rd_addr == ADDR_W'(i)) rd_word = mem_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_err_q <= 1'b0;
            v1_q     <= 1'b0;
            e1_q     <= 1'b0;
            d1_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= bus.wr_enb && !wr_in;
            v1_q     <= bus.rd_enb;
            e1_q     <= bus.rd_enb && !rd_in;
            if (bus.rd_enb) d1_q <= rd_word;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] d2_q;
        logic              v2_q, e2_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                if (v1_q) d2_q <= d1_q;
            end
        end
        assign bus.rd_valid = v2_q;
        assign bus.rd_err   = e2_q;
        assign bus.rd_data  = d2_q;
    end else begin : g_lat1
        assign bus.rd_valid = v1_q;
        assign bus.rd_err   = e1_q;
        assign bus.rd_data  = d1_q;
    end
endmodule

// File: tb/tb_ram_dp_mem.sv
// tb_ram_dp_mem: directed bench; one stimulus stream feeds three configurations
// (b0: defaults, b1: RD_LAT=2, b2: DEPTH=12).
module tb_ram_dp_mem;
    logic        clk, rst;
    logic        wr_enb, rd_enb;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;
    int          n_chk = 0;
    int          n_fail = 0;

    ram_dp_mem_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
    ram_dp_mem_if #(.DATA_W(32), .ADDR_W(4)) b1 ();
    ram_dp_mem_if #(.DATA_W(32), .ADDR_W(4)) b2 ();

    assign b0.wr_enb = wr_enb;  assign b1.wr_enb = wr_enb;  assign b2.wr_enb = wr_enb;
    assign b0.wr_addr = wr_addr; assign b1.wr_addr = wr_addr; assign b2.wr_addr = wr_addr;
    assign b0.wr_data = wr_data; assign b1.wr_data = wr_data; assign b2.wr_data = wr_data;
    assign b0.wr_be = wr_be;    assign b1.wr_be = wr_be;    assign b2.wr_be = wr_be;
    assign b0.rd_enb = rd_enb;  assign b1.rd_enb = rd_enb;  assign b2.rd_enb = rd_enb;
    assign b0.rd_addr = rd_addr; assign b1.rd_addr = rd_addr; assign b2.rd_addr = rd_addr;

    ram_dp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    ram_dp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
    ram_dp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_enb = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_enb = 1'b1; rd_addr = a;
    endtask

    task automatic idle;
        wr_enb = 1'b0; rd_enb = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; idle(); wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        step(); step();
        n_chk++; if (b0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", b0.rd_valid); end
        n_chk++; if (b1.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b want 0", b1.rd_valid); end
        n_chk++; if (b0.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data0: got %h want 0", b0.rd_data); end
        n_chk++; if (b2.rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rderr2: got %b want 0", b2.rd_err); end
        n_chk++; if (b2.wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wrerr2: got %b want 0", b2.wr_err); end
        rst = 1'b0;
        rd(4'd0); step(); idle();
        n_chk++; if (b0.rd_data !== 32'h0 || b0.rd_valid !== 1'b1) begin n_fail++; $display("FAIL reset_mem0: got %h/%b want 0/1", b0.rd_data, b0.rd_valid); end
        step();
    endtask

    task automatic test_byte_merge;
        wr(4'd3, 32'hAABBCCDD, 4'hF); step();
        wr(4'd3, 32'h11223344, 4'b0101); step();
        idle(); rd(4'd3); step(); idle();
        n_chk++; if (b0.rd_valid !== 1'b1) begin n_fail++; $display("FAIL merge_valid: got %b want 1", b0.rd_valid); end
        n_chk++; if (b0.rd_data !== 32'hAA22CC44) begin n_fail++; $display("FAIL merge_data: got %h want aa22cc44", b0.rd_data); end
        n_chk++; if (b0.rd_err !== 1'b0) begin n_fail++; $display("FAIL merge_err: got %b want 0", b0.rd_err); end
        step();
        n_chk++; if (b0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b want 0", b0.rd_valid); end
        n_chk++; if (b0.rd_data !== 32'hAA22CC44) begin n_fail++; $display("FAIL hold_data: got %h want aa22cc44", b0.rd_data); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 4; k++) begin wr(4'(k), 32'(k), 4'hF); step(); end
        idle();
        for (int k = 0; k < 6; k++) begin
            rd_enb = (k < 4); rd_addr = 4'(k);
            step();
            n_chk++; if (b1.rd_valid !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want %b", k, b1.rd_valid, (k >= 1 && k <= 4)); end
            if (k >= 1 && k <= 4) begin
                n_chk++; if (b1.rd_data !== 32'(k - 1)) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, b1.rd_data, 32'(k - 1)); end
            end
            if (k < 4) begin
                n_chk++; if (b0.rd_valid !== 1'b1 || b0.rd_data !== 32'(k)) begin n_fail++; $display("FAIL b2b_lat1_%0d: got %h/%b want %h/1", k, b0.rd_data, b0.rd_valid, 32'(k)); end
            end
        end
        idle();
    endtask

    task automatic test_out_of_range;
        wr(4'd1, 32'h01010101, 4'hF); step();
        wr(4'd13, 32'hCAFEF00D, 4'hF); step();
        n_chk++; if (b2.wr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wrerr: got %b want 1", b2.wr_err); end
        n_chk++; if (b0.wr_err !== 1'b0) begin n_fail++; $display("FAIL inrange_wrerr: got %b want 0", b0.wr_err); end
        idle(); step();
        n_chk++; if (b2.wr_err !== 1'b0) begin n_fail++; $display("FAIL oor_wrerr_pulse: got %b want 0", b2.wr_err); end
        wr(4'd12, 32'h0, 4'h0); step();
        n_chk++; if (b2.wr_err !== 1'b1) begin n_fail++; $display("FAIL oor_edge_wrerr: got %b want 1", b2.wr_err); end
        wr(4'd11, 32'hFFFFFFFF, 4'h0); step();
        n_chk++; if (b2.wr_err !== 1'b0) begin n_fail++; $display("FAIL be0_wrerr: got %b want 0", b2.wr_err); end
        idle();
        rd(4'd13); step();
        n_chk++; if (b2.rd_valid !== 1'b1 || b2.rd_err !== 1'b1 || b2.rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_rd13: got %h/%b/%b want 0/1/1", b2.rd_data, b2.rd_valid, b2.rd_err); end
        n_chk++; if (b0.rd_data !== 32'hCAFEF00D || b0.rd_err !== 1'b0) begin n_fail++; $display("FAIL full_rd13: got %h/%b want cafef00d/0", b0.rd_data, b0.rd_err); end
        rd(4'd12); step();
        n_chk++; if (b2.rd_err !== 1'b1 || b2.rd_data !== 32'h0) begin n_fail++; $display("FAIL oor_rd12: got %h/%b want 0/1", b2.rd_data, b2.rd_err); end
        rd(4'd11); step();
        n_chk++; if (b2.rd_err !== 1'b0 || b2.rd_data !== 32'h0) begin n_fail++; $display("FAIL be0_rd11: got %h/%b want 0/0", b2.rd_data, b2.rd_err); end
        rd(4'd1); step(); idle();
        n_chk++; if (b2.rd_data !== 32'h01010101 || b2.rd_err !== 1'b0) begin n_fail++; $display("FAIL nowrap_rd1: got %h/%b want 01010101/0", b2.rd_data, b2.rd_err); end
        step();
        n_chk++; if (b2.rd_valid !== 1'b0 || b2.rd_err !== 1'b0 || b2.rd_data !== 32'h01010101) begin n_fail++; $display("FAIL oor_idle: got %h/%b/%b want 01010101/0/0", b2.rd_data, b2.rd_valid, b2.rd_err); end
    endtask

    task automatic test_collision;
        wr(4'd5, 32'hDEADBEEF, 4'b0011); rd(4'd5); step();
        n_chk++; if (b0.rd_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL collide: got %h want 0000beef", b0.rd_data); end
        wr(4'd6, 32'h11111111, 4'hF); rd(4'd3); step();
        n_chk++; if (b0.rd_data !== 32'h3) begin n_fail++; $display("FAIL indep_rd3: got %h want 00000003", b0.rd_data); end
        idle(); rd(4'd6); step();
        n_chk++; if (b0.rd_data !== 32'h11111111) begin n_fail++; $display("FAIL raw_next: got %h want 11111111", b0.rd_data); end
        rd(4'd5); step(); idle();
        n_chk++; if (b0.rd_data !== 32'h0000BEEF) begin n_fail++; $display("FAIL collide_stored: got %h want 0000beef", b0.rd_data); end
    endtask

    task automatic test_lane;
        wr(4'd7, 32'hFFFFFFFF, 4'b1000); step();
        idle(); rd(4'd7); step(); idle();
        n_chk++; if (b0.rd_data !== 32'hFF000000) begin n_fail++; $display("FAIL lane: got %h want ff000000", b0.rd_data); end
    endtask

    task automatic test_reset_mid_read;
        wr(4'd1, 32'h55, 4'hF); step();
        idle(); rd(4'd1); step();
        rst = 1'b1; rd(4'd1); wr(4'd2, 32'hFFFFFFFF, 4'hF); step();
        n_chk++; if (b1.rd_valid !== 1'b0 || b1.rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_at: got %h/%b want 0/0", b1.rd_data, b1.rd_valid); end
        n_chk++; if (b0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop0: got %b want 0", b0.rd_valid); end
        rst = 1'b0; idle(); step();
        n_chk++; if (b1.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_p1: got %b want 0", b1.rd_valid); end
        n_chk++; if (b0.rd_valid !== 1'b0 || b0.wr_err !== 1'b0) begin n_fail++; $display("FAIL rst_after0: got %b/%b want 0/0", b0.rd_valid, b0.wr_err); end
        step();
        n_chk++; if (b1.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_p2: got %b want 0", b1.rd_valid); end
        rd(4'd1); step();
        rd(4'd2); step(); idle();
        n_chk++; if (b1.rd_valid !== 1'b1 || b1.rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_rd1: got %h/%b want 0/1", b1.rd_data, b1.rd_valid); end
        step();
        n_chk++; if (b1.rd_valid !== 1'b1 || b1.rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr_drop: got %h/%b want 0/1", b1.rd_data, b1.rd_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_back_to_back();
        test_out_of_range();
        test_collision();
        test_lane();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
